// File: rtl/explosion_unit_pkg.sv
// rtl/explosion_unit_pkg.sv - shared screen constants, slot record and flame geometry helpers
package explosion_unit_pkg;

  localparam int TILE     = 16;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;
  localparam int RGB_W    = 12;
  localparam int GEO_W    = COORD_W + 1;

  typedef enum logic {SLOT_IDLE, SLOT_BURNING} slot_state_e;

  typedef struct packed {
    slot_state_e        state;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } slot_t;

  function automatic logic [GEO_W-1:0] min_geo(input logic [GEO_W-1:0] a, input logic [GEO_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic in_span(input logic [GEO_W-1:0] p, input logic [GEO_W-1:0] lo,
                                   input logic [GEO_W-1:0] hi);
    return (p >= lo) && (p <= hi);
  endfunction

  // An arm clipped off-screen leaves lo > hi; it must never count as overlapping.
  function automatic logic spans_overlap(input logic [GEO_W-1:0] a_lo, input logic [GEO_W-1:0] a_hi,
                                         input logic [GEO_W-1:0] b_lo, input logic [GEO_W-1:0] b_hi);
    return (a_lo <= b_hi) && (b_lo <= a_hi) && (b_lo <= b_hi);
  endfunction

  function automatic logic [RGB_W-1:0] flame_color(input logic [1:0] frame, input logic [3:0] row,
                                                   input logic [3:0] col);
    return {4'hF, ~frame, row[3:2], 4'(row + col)};
  endfunction

endpackage

// File: rtl/explosion_rom.sv
// rtl/explosion_rom.sv - single-cycle synchronous flame sprite ROM, one bank per animation frame
module explosion_rom
  import explosion_unit_pkg::*;
(
  input  logic             clk,
  input  logic [1:0]       frame,
  input  logic [3:0]       row,
  input  logic [3:0]       col,
  output logic [RGB_W-1:0] color_data
);

  logic [RGB_W-1:0] color_q;

  always_ff @(posedge clk) begin
    color_q <= flame_color(frame, row, col);
  end

  assign color_data = color_q;

endmodule

// File: rtl/explosion_unit.sv
// rtl/explosion_unit.sv - flame slot array: detonation capture, per-slot cross hit tests, pixel/player outputs
module explosion_unit
  import explosion_unit_pkg::*;
#(
  parameter int NUM_EXPL    = 4,
  parameter int RANGE       = 2,
  parameter int EXPL_CLOCKS = 25_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               det_valid,
  input  logic [COORD_W-1:0] det_x,
  input  logic [COORD_W-1:0] det_y,
  input  logic [COORD_W-1:0] b_x,
  input  logic [COORD_W-1:0] b_y,
  input  logic [COORD_W-1:0] v_x,
  input  logic [COORD_W-1:0] v_y,
  output logic               explosion_on,
  output logic [RGB_W-1:0]   rgb_out,
  output logic               player_hit,
  output logic               det_drop
);

  localparam int TW      = $clog2(EXPL_CLOCKS);
  localparam int QUARTER = EXPL_CLOCKS / 4;
  localparam logic [GEO_W-1:0] ARM   = GEO_W'(RANGE * TILE);
  localparam logic [GEO_W-1:0] FAR   = GEO_W'((RANGE + 1) * TILE - 1);
  localparam logic [GEO_W-1:0] T_M1  = GEO_W'(TILE - 1);
  localparam logic [GEO_W-1:0] X_MAX = GEO_W'(SCREEN_W - 1);
  localparam logic [GEO_W-1:0] Y_MAX = GEO_W'(SCREEN_H - 1);
  localparam logic [TW-1:0]    T_LAST = TW'(EXPL_CLOCKS - 1);

  slot_t         slot_q  [NUM_EXPL];
  slot_t         slot_d  [NUM_EXPL];
  logic [TW-1:0] timer_q [NUM_EXPL];
  logic [TW-1:0] timer_d [NUM_EXPL];
  logic [1:0]    frame   [NUM_EXPL];
  logic [NUM_EXPL-1:0] busy, pix_hit, ply_hit, match, free_sel;
  logic          free_taken;

  logic [GEO_W-1:0] px, py, bx, by, bx_hi, by_hi;
  assign px    = {1'b0, v_x};
  assign py    = {1'b0, v_y};
  assign bx    = {1'b0, b_x};
  assign by    = {1'b0, b_y};
  assign bx_hi = bx + T_M1;
  assign by_hi = by + T_M1;

  for (genvar g = 0; g < NUM_EXPL; g++) begin : g_slot
    logic [GEO_W-1:0] cx, cy, cx_hi, cy_hi, h_lo, h_hi, v_lo, v_hi;
    assign busy[g] = (slot_q[g].state == SLOT_BURNING);
    assign cx      = {1'b0, slot_q[g].x};
    assign cy      = {1'b0, slot_q[g].y};
    assign cx_hi   = min_geo(cx + T_M1, X_MAX);
    assign cy_hi   = min_geo(cy + T_M1, Y_MAX);
    assign h_lo    = (cx >= ARM) ? cx - ARM : '0;
    assign v_lo    = (cy >= ARM) ? cy - ARM : '0;
    assign h_hi    = min_geo(cx + FAR, X_MAX);
    assign v_hi    = min_geo(cy + FAR, Y_MAX);
    assign pix_hit[g] = busy[g] &&
                        ((in_span(px, h_lo, h_hi) && in_span(py, cy, cy_hi)) ||
                         (in_span(px, cx, cx_hi) && in_span(py, v_lo, v_hi)));
    assign ply_hit[g] = busy[g] &&
                        ((spans_overlap(bx, bx_hi, h_lo, h_hi) && spans_overlap(by, by_hi, cy, cy_hi)) ||
                         (spans_overlap(bx, bx_hi, cx, cx_hi) && spans_overlap(by, by_hi, v_lo, v_hi)));
    assign frame[g] = (timer_q[g] >= TW'(3 * QUARTER)) ? 2'd3 :
                      (timer_q[g] >= TW'(2 * QUARTER)) ? 2'd2 :
                      (timer_q[g] >= TW'(QUARTER))     ? 2'd1 : 2'd0;
  end

  // Lowest-index hitting slot owns the pixel.
  logic       hit_any;
  logic [1:0] hit_frame;
  always_comb begin
    hit_any   = 1'b0;
    hit_frame = 2'd0;
    for (int i = NUM_EXPL - 1; i >= 0; i--) begin
      if (pix_hit[i]) begin
        hit_any   = 1'b1;
        hit_frame = frame[i];
      end
    end
  end

  logic [RGB_W-1:0] color_data;
  explosion_rom u_rom (
    .clk        (clk),
    .frame      (hit_frame),
    .row        (v_y[3:0]),
    .col        (v_x[3:0]),
    .color_data (color_data)
  );

  logic explosion_on_q, explosion_on_d;
  logic player_hit_q, player_hit_d;
  logic det_drop_q, det_drop_d;

  // Match and free decisions look only at start-of-cycle state; retrigger beats expiry.
  always_comb begin
    match      = '0;
    free_sel   = '0;
    free_taken = 1'b0;
    slot_d     = slot_q;
    timer_d    = timer_q;
    for (int i = 0; i < NUM_EXPL; i++) begin
      match[i]    = busy[i] && (slot_q[i].x == det_x) && (slot_q[i].y == det_y);
      free_sel[i] = !busy[i] && !free_taken;
      free_taken  = free_taken || !busy[i];
      if (busy[i]) begin
        if (timer_q[i] == T_LAST) begin
          slot_d[i].state = SLOT_IDLE;
          timer_d[i]      = '0;
        end else begin
          timer_d[i] = timer_q[i] + 1'b1;
        end
      end
    end
    if (det_valid) begin
      for (int i = 0; i < NUM_EXPL; i++) begin
        if (match[i]) begin
          slot_d[i].state = SLOT_BURNING;
          timer_d[i]      = '0;
        end else if (!(|match) && free_sel[i]) begin
          slot_d[i] = '{SLOT_BURNING, det_x, det_y};
          timer_d[i] = '0;
        end
      end
    end
    det_drop_d     = det_valid && !(|match) && !(|free_sel);
    explosion_on_d = hit_any;
    player_hit_d   = |ply_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_EXPL; i++) begin
        slot_q[i]  <= '{SLOT_IDLE, '0, '0};
        timer_q[i] <= '0;
      end
      explosion_on_q <= 1'b0;
      player_hit_q   <= 1'b0;
      det_drop_q     <= 1'b0;
    end else begin
      slot_q         <= slot_d;
      timer_q        <= timer_d;
      explosion_on_q <= explosion_on_d;
      player_hit_q   <= player_hit_d;
      det_drop_q     <= det_drop_d;
    end
  end

  assign explosion_on = explosion_on_q;
  assign rgb_out      = explosion_on_q ? color_data : '0;
  assign player_hit   = player_hit_q;
  assign det_drop     = det_drop_q;

endmodule

// File: tb/tb_explosion_unit.sv
// tb/tb_explosion_unit.sv - directed and randomized bench for explosion_unit against a pixel-level flame model
module tb_explosion_unit;

  localparam int EXPL = 8;
  localparam int RNG  = 2;
  localparam int N    = 4;
  localparam int FAR_AWAY = 1000;

  logic       clk = 1'b0;
  logic       reset, det_valid;
  logic [9:0] det_x, det_y, b_x, b_y, v_x, v_y;
  logic       explosion_on, player_hit, det_drop;
  logic [11:0] rgb_out;

  always #5 clk = ~clk;

  explosion_unit #(.NUM_EXPL(N), .RANGE(RNG), .EXPL_CLOCKS(EXPL)) dut (
    .clk          (clk),
    .reset        (reset),
    .det_valid    (det_valid),
    .det_x        (det_x),
    .det_y        (det_y),
    .b_x          (b_x),
    .b_y          (b_y),
    .v_x          (v_x),
    .v_y          (v_y),
    .explosion_on (explosion_on),
    .rgb_out      (rgb_out),
    .player_hit   (player_hit),
    .det_drop     (det_drop)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: each flame is a list of covered screen pixels, tested point by point.
  bit m_act [N];
  int m_x [N];
  int m_y [N];
  int m_age [N];

  function automatic bit on_flame(input int k, input int px, input int py);
    bit horiz, vert;
    if (!m_act[k] || px > 639 || py > 479) return 1'b0;
    horiz = (py >= m_y[k]) && (py < m_y[k] + 16) &&
            (px >= m_x[k] - RNG * 16) && (px < m_x[k] + (RNG + 1) * 16);
    vert  = (px >= m_x[k]) && (px < m_x[k] + 16) &&
            (py >= m_y[k] - RNG * 16) && (py < m_y[k] + (RNG + 1) * 16);
    return horiz || vert;
  endfunction

  task automatic step(input bit rst, input bit dv, input int dx, input int dy,
                      input int bx, input int by, input int vx, input int vy);
    int e_on, e_rgb, e_hit, e_drop, fr, row, col, mi, fi;
    e_on = 0; e_rgb = 0; e_hit = 0; e_drop = 0; mi = -1; fi = -1;
    reset = rst; det_valid = dv;
    det_x = 10'(dx); det_y = 10'(dy);
    b_x = 10'(bx); b_y = 10'(by);
    v_x = 10'(vx); v_y = 10'(vy);
    if (!rst) begin
      for (int k = 0; k < N && e_on == 0; k++) begin
        if (on_flame(k, vx, vy)) begin
          e_on  = 1;
          fr    = m_age[k] * 4 / EXPL;
          row   = vy % 16;
          col   = vx % 16;
          e_rgb = 15 * 256 + ((3 - fr) * 4 + row / 4) * 16 + (row + col) % 16;
        end
      end
      for (int k = 0; k < N && e_hit == 0; k++)
        for (int i = 0; i < 16; i++)
          for (int j = 0; j < 16; j++)
            if (on_flame(k, bx + i, by + j)) e_hit = 1;
      for (int k = 0; k < N; k++) begin
        if (m_act[k] && m_x[k] == dx && m_y[k] == dy && mi < 0) mi = k;
        if (!m_act[k] && fi < 0) fi = k;
      end
      e_drop = (dv && mi < 0 && fi < 0) ? 1 : 0;
    end
    @(posedge clk);
    #1;
    check_eq("explosion_on", 32'(explosion_on), e_on);
    check_eq("rgb_out", 32'(rgb_out), e_rgb);
    check_eq("player_hit", 32'(player_hit), e_hit);
    check_eq("det_drop", 32'(det_drop), e_drop);
    if (rst) begin
      for (int k = 0; k < N; k++) begin m_act[k] = 0; m_age[k] = 0; end
    end else begin
      for (int k = 0; k < N; k++)
        if (m_act[k]) begin
          if (m_age[k] == EXPL - 1) begin m_act[k] = 0; m_age[k] = 0; end
          else m_age[k]++;
        end
      if (dv && mi >= 0) begin
        m_act[mi] = 1; m_age[mi] = 0;
      end else if (dv && fi >= 0) begin
        m_act[fi] = 1; m_age[fi] = 0; m_x[fi] = dx; m_y[fi] = dy;
      end
    end
  endtask

  task automatic idle(input int n, input int bx, input int by, input int vx, input int vy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, bx, by, vx, vy);
  endtask

  int rr, rdv, rdx, rdy, rk, rvx, rvy, rbx, rby;

  initial begin
    for (int k = 0; k < N; k++) begin m_act[k] = 0; m_x[k] = 0; m_y[k] = 0; m_age[k] = 0; end
    step(1, 0, 0, 0, FAR_AWAY, FAR_AWAY, FAR_AWAY, FAR_AWAY);
    step(1, 1, 160, 160, FAR_AWAY, FAR_AWAY, 160, 160);
    check_eq("reset_explosion_on", 32'(explosion_on), 0);
    check_eq("reset_rgb", 32'(rgb_out), 0);

    // single flame edges and lifetime
    step(0, 1, 160, 160, FAR_AWAY, FAR_AWAY, FAR_AWAY, FAR_AWAY);
    step(0, 0, 0, 0, FAR_AWAY, FAR_AWAY, 128, 168);
    check_eq("t1_left_end_on", 32'(explosion_on), 1);
    step(0, 0, 0, 0, FAR_AWAY, FAR_AWAY, 199, 160);
    check_eq("t1_right_arm_on", 32'(explosion_on), 1);
    step(0, 0, 0, 0, FAR_AWAY, FAR_AWAY, 127, 168);
    check_eq("t1_left_outside_off", 32'(explosion_on), 0);
    idle(6, FAR_AWAY, FAR_AWAY, 160, 160);
    check_eq("t1_expired_off", 32'(explosion_on), 0);

    // origin: left and upper arms clipped
    step(0, 1, 0, 0, FAR_AWAY, FAR_AWAY, FAR_AWAY, FAR_AWAY);
    step(0, 0, 0, 0, FAR_AWAY, FAR_AWAY, 32, 0);
    check_eq("t2_right_arm_on", 32'(explosion_on), 1);
    step(0, 0, 0, 0, FAR_AWAY, FAR_AWAY, 1008, 0);
    check_eq("t2_no_wrap_x", 32'(explosion_on), 0);
    step(0, 0, 0, 0, FAR_AWAY, FAR_AWAY, 0, 1008);
    check_eq("t2_no_wrap_y", 32'(explosion_on), 0);
    idle(8, FAR_AWAY, FAR_AWAY, 0, 47);

    // slot exhaustion
    for (int i = 0; i < 5; i++) step(0, 1, 16 * i * 3, 320, FAR_AWAY, FAR_AWAY, FAR_AWAY, FAR_AWAY);
    check_eq("t3_fifth_dropped", 32'(det_drop), 1);
    step(0, 0, 0, 0, FAR_AWAY, FAR_AWAY, 0, 320);
    check_eq("t3_drop_one_cycle", 32'(det_drop), 0);
    idle(9, FAR_AWAY, FAR_AWAY, 48, 320);

    // retrigger at timer 6 extends lifetime
    step(0, 1, 160, 160, FAR_AWAY, FAR_AWAY, 160, 160);
    idle(6, FAR_AWAY, FAR_AWAY, 160, 160);
    step(0, 1, 160, 160, FAR_AWAY, FAR_AWAY, 160, 160);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, FAR_AWAY, FAR_AWAY, 160, 160);
      check_eq("t4_persist", 32'(explosion_on), 1);
    end
    step(0, 0, 0, 0, FAR_AWAY, FAR_AWAY, 160, 160);
    check_eq("t4_expired", 32'(explosion_on), 0);

    // player overlap
    step(0, 1, 160, 160, 176, 150, FAR_AWAY, FAR_AWAY);
    step(0, 0, 0, 0, 176, 150, FAR_AWAY, FAR_AWAY);
    check_eq("t5_player_hit", 32'(player_hit), 1);
    idle(8, 176, 150, FAR_AWAY, FAR_AWAY);
    check_eq("t5_player_clear", 32'(player_hit), 0);

    // reset mid-flame
    step(0, 1, 160, 160, 176, 150, 160, 160);
    idle(3, 176, 150, 160, 160);
    step(1, 0, 0, 0, 176, 150, 160, 160);
    check_eq("t6_reset_on", 32'(explosion_on), 0);
    check_eq("t6_reset_hit", 32'(player_hit), 0);
    step(0, 1, 160, 160, 176, 150, 160, 160);
    step(0, 0, 0, 0, 176, 150, 160, 160);
    check_eq("t6_after_reset_on", 32'(explosion_on), 1);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      rr  = ($urandom_range(0, 199) == 0) ? 1 : 0;
      rdv = ($urandom_range(0, 3) == 0) ? 1 : 0;
      rdx = 16 * int'($urandom_range(0, 39));
      rdy = 16 * int'($urandom_range(0, 29));
      rk  = int'($urandom_range(0, N - 1));
      if (rdv == 1 && m_act[rk] && $urandom_range(0, 2) == 0) begin
        rdx = m_x[rk]; rdy = m_y[rk];
      end
      rvx = (m_x[rk] + int'($urandom_range(0, 111)) - 48) & 1023;
      rvy = (m_y[rk] + int'($urandom_range(0, 111)) - 48) & 1023;
      rbx = (m_x[rk] + int'($urandom_range(0, 111)) - 64) & 1023;
      rby = (m_y[rk] + int'($urandom_range(0, 111)) - 64) & 1023;
      step(rr[0], rdv[0], rdx, rdy, rbx, rby, rvx, rvy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
